// File: rtl/uart_input_buffer_pkg.sv
// Shared types and constants for the UART plaintext input buffer.
package uart_input_buffer_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        ASM_IDLE,
        ASM_COLLECT,
        ASM_XX
    } in_asm_fsm_e;

    typedef enum logic [1:0] {
        OUT_EMPTY,
        OUT_READ,
        OUT_VALID,
        OUT_XX
    } in_out_fsm_e;

endpackage

// File: rtl/uart_input_buffer_fifo.sv
// Block FIFO with registered (1-cycle latency) read data and active-low async reset.
module Fifo_Buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_wr, w_do_rd;

    // Fullness is judged before any same-cycle pop, so a pop never makes room for a write.
    assign w_do_wr = wr_en && !full;
    assign w_do_rd = rd_en && !empty;
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            rd_data <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                rd_data <= r_mem[r_rptr];
                r_rptr  <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_input_buffer.sv
// Assembles UART bytes into 128-bit blocks, queues them, and hands them to the AES core.
module uart_input_buffer
    import uart_input_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_done,
    output logic [DATA_WIDTH-1:0] text_out,
    output logic                  text_valid,
    input  logic                  text_ready,
    output logic                  buffer_full,
    output logic                  overflow_err,
    output logic                  timeout_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    in_asm_fsm_e                 r_asm_state, w_asm_next;
    in_out_fsm_e                 r_out_state, w_out_next;
    logic [0:BLOCK_BYTES-1][7:0] r_asm, w_block;
    logic [3:0]                  r_byte_cnt, w_cnt_next;
    logic [IDLE_W-1:0]           r_idle, w_idle_next;
    logic                        w_store, w_wr, w_ovf, w_tmo, w_rden;
    logic                        r_overflow, r_timeout;
    logic [DATA_WIDTH-1:0]       r_text_out, w_fifo_rd;
    logic                        w_fifo_full, w_fifo_empty;

    // The 16th byte bypasses the assembly register so the block enqueues in its own cycle.
    always_comb begin
        w_block                  = r_asm;
        w_block[BLOCK_BYTES - 1] = rx_byte;
    end

    always_comb begin
        w_asm_next  = r_asm_state;
        w_cnt_next  = r_byte_cnt;
        w_idle_next = r_idle;
        w_store     = 1'b0;
        w_wr        = 1'b0;
        w_ovf       = 1'b0;
        w_tmo       = 1'b0;
        case (r_asm_state)
            ASM_IDLE: begin
                w_idle_next = '0;
                if (rx_done) begin
                    w_store    = 1'b1;
                    w_cnt_next = 4'd1;
                    w_asm_next = ASM_COLLECT;
                end
            end
            ASM_COLLECT: begin
                if (rx_done) begin
                    w_store     = 1'b1;
                    w_idle_next = '0;
                    if (r_byte_cnt == 4'(BLOCK_BYTES - 1)) begin
                        w_cnt_next = '0;
                        w_asm_next = ASM_IDLE;
                        w_wr       = !w_fifo_full;
                        w_ovf      = w_fifo_full;
                    end else begin
                        w_cnt_next = r_byte_cnt + 4'd1;
                    end
                end else if (r_idle == IDLE_LAST) begin
                    w_tmo       = 1'b1;
                    w_cnt_next  = '0;
                    w_idle_next = '0;
                    w_asm_next  = ASM_IDLE;
                end else begin
                    w_idle_next = r_idle + 1'b1;
                end
            end
            default: begin
                w_asm_next  = ASM_XX;
                w_cnt_next  = 'x;
                w_idle_next = 'x;
                w_store     = 1'bx;
                w_wr        = 1'bx;
                w_ovf       = 1'bx;
                w_tmo       = 1'bx;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm_state <= ASM_IDLE;
            r_byte_cnt  <= '0;
            r_idle      <= '0;
            r_asm       <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_asm_state <= w_asm_next;
            r_byte_cnt  <= w_cnt_next;
            r_idle      <= w_idle_next;
            r_overflow  <= w_ovf;
            r_timeout   <= w_tmo;
            if (w_store) begin
                r_asm[r_byte_cnt] <= rx_byte;
            end
        end
    end

    Fifo_Buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (~reset),
        .wr_en   (w_wr),
        .wr_data (w_block),
        .rd_en   (w_rden),
        .rd_data (w_fifo_rd),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    always_comb begin
        w_out_next = r_out_state;
        w_rden     = 1'b0;
        case (r_out_state)
            OUT_EMPTY: begin
                if (!w_fifo_empty) begin
                    w_rden     = 1'b1;
                    w_out_next = OUT_READ;
                end
            end
            OUT_READ:  w_out_next = OUT_VALID;
            OUT_VALID: begin
                if (text_ready) begin
                    w_out_next = OUT_EMPTY;
                end
            end
            default: begin
                w_out_next = OUT_XX;
                w_rden     = 1'bx;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_state <= OUT_EMPTY;
            r_text_out  <= '0;
        end else begin
            r_out_state <= w_out_next;
            if (r_out_state == OUT_READ) begin
                r_text_out <= w_fifo_rd;
            end
        end
    end

    assign text_out     = r_text_out;
    assign text_valid   = (r_out_state == OUT_VALID);
    assign buffer_full  = w_fifo_full;
    assign overflow_err = r_overflow;
    assign timeout_err  = r_timeout;

endmodule
